// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle for fifo_wr_arbiter: requester handshakes in,
// FIFO write port and grant status out.
`timescale 1ns/1ps
interface fifo_wr_arbiter_if #(
  parameter int data_Size = 8,
  parameter int num_Req   = 4
);
  localparam int ID_W = $clog2(num_Req);

  logic [num_Req-1:0]           req_Valid;
  logic [num_Req*data_Size-1:0] req_Data;
  logic [num_Req-1:0]           req_Ready;
  logic                         fifo_Full;
  logic [data_Size-1:0]         write_Data;
  logic                         w_Inc;
  logic [ID_W-1:0]              grant_Id;
  logic                         busy;

  modport master (
    output req_Valid, req_Data, fifo_Full,
    input  req_Ready, write_Data, w_Inc, grant_Id, busy
  );

  modport slave (
    input  req_Valid, req_Data, fifo_Full,
    output req_Ready, write_Data, w_Inc, grant_Id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port from num_Req requesters.
// Each grant moves up to burst_Len beats; arbitration takes one idle cycle.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int data_Size = 8,
  parameter int num_Req   = 4,
  parameter int burst_Len = 4
) (
  input logic          w_Clk,
  input logic          w_Rst,
  fifo_wr_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no grant; pick next valid requester after last_grant
  // GRANT | grant_id owns the FIFO until burst end or its valid drops
  typedef enum logic {IDLE, GRANT} state_t;

  localparam int ID_W  = $clog2(num_Req);
  localparam int CNT_W = $clog2(burst_Len) + 1;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    pick, idx;
  logic [ID_W:0]      sum;
  logic               pick_ok;
  logic [num_Req-1:0] ready;
  logic               inc;
  logic [data_Size-1:0] wdata;
  logic [data_Size-1:0] words [num_Req];

  for (genvar k = 0; k < num_Req; k++) begin : g_unpack
    assign words[k] = bus.req_Data[k*data_Size +: data_Size];
  end

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = num_Req; i >= 1; i--) begin
      sum = {1'b0, last_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(num_Req))
        sum = sum - (ID_W+1)'(num_Req);
      idx = ID_W'(sum);
      if (bus.req_Valid[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ready   = '0;
    inc     = 1'b0;
    wdata   = '0;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ready[grant_q] = ~bus.fifo_Full;
        inc            = bus.req_Valid[grant_q] & ~bus.fifo_Full;
        wdata          = words[grant_q];
        if (!bus.req_Valid[grant_q]) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else if (inc) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(burst_Len - 1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_Clk or negedge w_Rst) begin
    if (!w_Rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(num_Req - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_Ready  = ready;
  assign bus.w_Inc      = inc;
  assign bus.write_Data = wdata;
  assign bus.grant_Id   = grant_q;
  assign bus.busy       = (state_q == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester word sources, a write scoreboard,
// cycle logs for timing patterns, and a table of combinational GRANT vectors.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int DS = 8;
  localparam int NR = 4;
  localparam int BL = 4;

  logic w_Clk = 1'b0;
  logic w_Rst;

  fifo_wr_arbiter_if #(.data_Size(DS), .num_Req(NR)) bus ();
  fifo_wr_arbiter #(.data_Size(DS), .num_Req(NR), .burst_Len(BL)) dut (
    .w_Clk (w_Clk),
    .w_Rst (w_Rst),
    .bus   (bus)
  );

  always #5 w_Clk = ~w_Clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic [7:0] d1;
    logic [3:0] exp_ready;
    logic       exp_inc;
    logic [7:0] exp_wd;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  beat_t expq[$];
  logic [7:0] src [NR][$];
  logic       inc_log  [64];
  logic       busy_log [64];
  logic [1:0] gid_log  [64];
  logic [3:0] rdy_log  [64];
  logic [NR-1:0] acc;
  vec_t vt [7];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      bus.req_Valid[k] = (src[k].size() > 0);
      bus.req_Data[k*DS +: DS] = (src[k].size() > 0) ? src[k][0] : 8'($urandom);
    end
  endtask

  task automatic push_exp(logic [1:0] id, logic [7:0] data);
    beat_t b;
    b.id = id;
    b.data = data;
    expq.push_back(b);
  endtask

  // Sample on the falling edge, then let the rising edge consume accepted words.
  task automatic tick();
    @(negedge w_Clk);
    if (cyc < 64) begin
      inc_log[cyc]  = bus.w_Inc;
      busy_log[cyc] = bus.busy;
      gid_log[cyc]  = bus.grant_Id;
      rdy_log[cyc]  = bus.req_Ready;
    end
    check("inc_while_full", 32'(bus.w_Inc & bus.fifo_Full), 0);
    check("ready_onehot0", 32'($onehot0(bus.req_Ready)), 1);
    if (!bus.busy) check("idle_wdata", 32'(bus.write_Data), 0);
    if (bus.w_Inc) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got id %0d data %0h, required no write", bus.grant_Id, bus.write_Data);
      end else begin
        beat_t e;
        e = expq.pop_front();
        check("write_id", 32'(bus.grant_Id), 32'(e.id));
        check("write_data", 32'(bus.write_Data), 32'(e.data));
      end
    end
    acc = bus.req_Valid & bus.req_Ready;
    @(posedge w_Clk);
    #1;
    for (int k = 0; k < NR; k++)
      if (acc[k] && src[k].size() > 0) void'(src[k].pop_front());
    drive();
    cyc++;
  endtask

  task automatic assert_rst();
    w_Rst = 1'b0;
    bus.fifo_Full = 1'b0;
    for (int k = 0; k < NR; k++) src[k].delete();
    expq.delete();
    drive();
  endtask

  task automatic release_rst();
    @(posedge w_Clk);
    #1;
    w_Rst = 1'b1;
    cyc = 0;
  endtask

  task automatic check_pat(string name, int sel, string pat);
    logic [31:0] a;
    logic [31:0] e;
    a = '0;
    e = '0;
    for (int i = 0; i < pat.len(); i++) begin
      a[i] = (sel == 0) ? inc_log[i] : busy_log[i];
      e[i] = (pat[i] == "1");
    end
    check(name, a, e);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_ready"}, 32'(bus.req_Ready), 0);
    check({tag, "_inc"},   32'(bus.w_Inc), 0);
    check({tag, "_wdata"}, 32'(bus.write_Data), 0);
    check({tag, "_gid"},   32'(bus.grant_Id), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    int nw;
    vt[0] = '{4'b0010, 1'b0, 8'hA1, 4'b0010, 1'b1, 8'hA1};
    vt[1] = '{4'b0010, 1'b1, 8'hA2, 4'b0000, 1'b0, 8'hA2};
    vt[2] = '{4'b0000, 1'b0, 8'hA3, 4'b0010, 1'b0, 8'hA3};
    vt[3] = '{4'b1101, 1'b0, 8'hA4, 4'b0010, 1'b0, 8'hA4};
    vt[4] = '{4'b1111, 1'b0, 8'hA5, 4'b0010, 1'b1, 8'hA5};
    vt[5] = '{4'b1111, 1'b1, 8'hA6, 4'b0000, 1'b0, 8'hA6};
    vt[6] = '{4'b1011, 1'b1, 8'hA7, 4'b0000, 1'b0, 8'hA7};

    assert_rst();
    #12;
    check_outputs_zero("reset");

    // Lone requester 2 with six words: burst of 4, re-arbitrate, then 2.
    for (int j = 0; j < 6; j++) begin
      src[2].push_back(8'(8'hA0 + j));
      push_exp(2'd2, 8'(8'hA0 + j));
    end
    drive();
    release_rst();
    repeat (10) tick();
    check_pat("solo_inc", 0, "0111101100");
    check_pat("solo_busy", 1, "0111101110");
    check("solo_regrant_id", 32'(gid_log[6]), 2);
    check("solo_sb_empty", expq.size(), 0);

    // All four continuously valid: round robin 0,1,2,3,0.
    assert_rst();
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < 8; j++) src[k].push_back(8'(k*16 + j));
    for (int g = 0; g < 4; g++)
      for (int j = 0; j < 4; j++) push_exp(2'(g), 8'(g*16 + j));
    for (int j = 4; j < 8; j++) push_exp(2'd0, 8'(j));
    drive();
    release_rst();
    repeat (25) tick();
    check_pat("rr_inc", 0, "0111101111011110111101111");
    nw = 0;
    for (int i = 0; i < 20; i++) nw += int'(inc_log[i]);
    check("rr_writes_in_20", nw, 16);
    check("rr_sb_empty", expq.size(), 0);

    // fifo_Full for 3 cycles after 2 beats of requester 1, then rotate to 2.
    assert_rst();
    for (int j = 0; j < 4; j++) begin
      src[1].push_back(8'(8'h10 + j));
      push_exp(2'd1, 8'(8'h10 + j));
    end
    for (int j = 0; j < 2; j++) begin
      src[2].push_back(8'(8'h20 + j));
      push_exp(2'd2, 8'(8'h20 + j));
    end
    drive();
    release_rst();
    for (int i = 0; i < 13; i++) begin
      bus.fifo_Full = (i >= 3 && i <= 5);
      tick();
    end
    for (int i = 3; i <= 5; i++) begin
      check("full_ready", 32'(rdy_log[i]), 0);
      check("full_gid", 32'(gid_log[i]), 1);
      check("full_busy", 32'(busy_log[i]), 1);
    end
    check_pat("full_inc", 0, "0110001101100");
    check("full_next_gid", 32'(gid_log[9]), 2);
    check("full_sb_empty", expq.size(), 0);

    // Requester 0 drops valid after 2 beats; requester 3 waiting.
    assert_rst();
    src[0].push_back(8'h05);
    src[0].push_back(8'h06);
    push_exp(2'd0, 8'h05);
    push_exp(2'd0, 8'h06);
    for (int j = 0; j < 4; j++) begin
      src[3].push_back(8'(8'h30 + j));
      push_exp(2'd3, 8'(8'h30 + j));
    end
    drive();
    release_rst();
    repeat (11) tick();
    check_pat("drop_inc", 0, "01100111100");
    check_pat("drop_busy", 1, "01110111100");
    check("drop_gid_gap", 32'(gid_log[3]), 0);
    check("drop_gid_next", 32'(gid_log[5]), 3);
    check("drop_sb_empty", expq.size(), 0);

    // fifo_Full already high in IDLE must not stop the grant.
    assert_rst();
    bus.fifo_Full = 1'b1;
    src[1].push_back(8'h40);
    src[1].push_back(8'h41);
    push_exp(2'd1, 8'h40);
    push_exp(2'd1, 8'h41);
    drive();
    release_rst();
    for (int i = 0; i < 8; i++) begin
      bus.fifo_Full = (i <= 3);
      tick();
    end
    check("fullidle_busy", 32'(busy_log[1]), 1);
    check("fullidle_gid", 32'(gid_log[1]), 1);
    check_pat("fullidle_inc", 0, "00001100");
    check_pat("fullidle_busy_pat", 1, "01111110");
    check("fullidle_sb_empty", expq.size(), 0);

    // Reset mid-burst of requester 1, then everyone valid: 0 wins first.
    assert_rst();
    for (int j = 0; j < 8; j++) src[1].push_back(8'(8'h50 + j));
    push_exp(2'd1, 8'h50);
    push_exp(2'd1, 8'h51);
    drive();
    release_rst();
    repeat (3) tick();
    w_Rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) tick();
    check("midrst_sb_empty", expq.size(), 0);
    src[1].delete();
    for (int k = 0; k < NR; k++)
      for (int j = 0; j < 4; j++) src[k].push_back(8'(8'h60 + k*16 + j));
    for (int j = 0; j < 4; j++) push_exp(2'd0, 8'(8'h60 + j));
    drive();
    release_rst();
    repeat (6) tick();
    check("midrst_first_gid", 32'(gid_log[1]), 0);
    check_pat("midrst_inc", 0, "011110");
    check("midrst_sb_after", expq.size(), 0);

    // Combinational GRANT vectors with requester 1 granted.
    assert_rst();
    bus.fifo_Full = 1'b1;
    src[1].push_back(8'h77);
    drive();
    release_rst();
    tick();
    for (int v = 0; v < 7; v++) begin
      bus.req_Valid = vt[v].valid;
      bus.fifo_Full = vt[v].full;
      for (int k = 0; k < NR; k++)
        bus.req_Data[k*DS +: DS] = (k == 1) ? vt[v].d1 : 8'($urandom);
      #1;
      check($sformatf("vec%0d_ready", v), 32'(bus.req_Ready), 32'(vt[v].exp_ready));
      check($sformatf("vec%0d_inc", v), 32'(bus.w_Inc), 32'(vt[v].exp_inc));
      check($sformatf("vec%0d_wdata", v), 32'(bus.write_Data), 32'(vt[v].exp_wd));
      check($sformatf("vec%0d_gid", v), 32'(bus.grant_Id), 1);
    end
    bus.fifo_Full = 1'b1;
    drive();
    assert_rst();
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
